// File: rtl/pwm_multi_pkg.sv
// Shared types and constants for the multi-channel PWM and its dead-time stage.
// Dead-time encodings are used only in builds with PWM_DEADTIME_EN defined.
package pwm_multi_pkg;

  localparam int unsigned PWM_WIDTH_DEF    = 16;
  localparam int unsigned PWM_CHANNELS_DEF = 4;
  localparam int unsigned PWM_DT_WIDTH_DEF = 8;

  // Value the period counter returns to on reset, disable and wrap
  localparam int unsigned CNT_RST = 0;

  typedef enum logic [2:0] {
    DT_IDLE,
    DT_WAIT_HI,
    DT_HIGH,
    DT_WAIT_LO,
    DT_LOW
  } dt_state_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Register-block side of the multi-channel PWM (control in, waveforms out).
// out_n and deadtime exist only when PWM_DEADTIME_EN is defined.
interface pwm_multi_if
  import pwm_multi_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH_DEF,
  parameter int unsigned CHANNELS = PWM_CHANNELS_DEF,
  parameter int unsigned DT_WIDTH = PWM_DT_WIDTH_DEF
) ();

  logic                      en;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      load;
  logic                      pending;
  logic [CHANNELS-1:0]       out;
  logic                      period_end;
`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0]       deadtime;
  logic [CHANNELS-1:0]       out_n;
`endif

  if (WIDTH < 1 || CHANNELS < 1 || DT_WIDTH < 1) begin : g_param_check
    $error("pwm_multi_if: WIDTH, CHANNELS and DT_WIDTH must be >= 1");
  end

  modport master (
    output en, period, duty, load,
`ifdef PWM_DEADTIME_EN
    output deadtime, input out_n,
`endif
    input  pending, out, period_end
  );

  modport slave (
    input  en, period, duty, load,
`ifdef PWM_DEADTIME_EN
    input  deadtime, output out_n,
`endif
    output pending, out, period_end
  );

endinterface

// File: rtl/pwm_multi_deadtime.sv
// Per-channel dead-time inserter: delays each rising edge of out/out_n until
// the raw compare has held its level for deadtime cycles. Built only with PWM_DEADTIME_EN.
`ifdef PWM_DEADTIME_EN
module pwm_multi_deadtime
  import pwm_multi_pkg::*;
#(
  parameter int unsigned DT_WIDTH = PWM_DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_raw,
  input  logic [DT_WIDTH-1:0] i_deadtime,
  output logic                o_out,
  output logic                o_out_n
);

  dt_state_e           r_state;
  logic [DT_WIDTH-1:0] r_wait;
  logic                r_out;
  logic                r_out_n;

  // r_wait holds the number of further same-level samples needed before rising
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DT_IDLE;
      r_wait  <= '0;
      r_out   <= 1'b0;
      r_out_n <= 1'b0;
    end else if (!i_en) begin
      r_state <= DT_IDLE;
      r_wait  <= '0;
      r_out   <= 1'b0;
      r_out_n <= 1'b0;
    end else if (i_raw) begin
      r_out_n <= 1'b0;
      case (r_state)
        DT_HIGH: r_out <= 1'b1;
        DT_WAIT_HI: begin
          if (r_wait <= DT_WIDTH'(1)) begin
            r_state <= DT_HIGH;
            r_out   <= 1'b1;
          end else begin
            r_wait <= r_wait - DT_WIDTH'(1);
            r_out  <= 1'b0;
          end
        end
        default: begin
          if (i_deadtime == '0) begin
            r_state <= DT_HIGH;
            r_out   <= 1'b1;
          end else begin
            r_state <= DT_WAIT_HI;
            r_wait  <= i_deadtime;
            r_out   <= 1'b0;
          end
        end
      endcase
    end else begin
      r_out <= 1'b0;
      case (r_state)
        DT_LOW: r_out_n <= 1'b1;
        DT_WAIT_LO: begin
          if (r_wait <= DT_WIDTH'(1)) begin
            r_state <= DT_LOW;
            r_out_n <= 1'b1;
          end else begin
            r_wait  <= r_wait - DT_WIDTH'(1);
            r_out_n <= 1'b0;
          end
        end
        default: begin
          if (i_deadtime == '0) begin
            r_state <= DT_LOW;
            r_out_n <= 1'b1;
          end else begin
            r_state <= DT_WAIT_LO;
            r_wait  <= i_deadtime;
            r_out_n <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_out   = r_out;
  assign o_out_n = r_out_n;

endmodule
`endif

// File: rtl/pwm_multi.sv
// N-channel PWM: shared period counter, double-buffered period/duty, per-channel compare.
// Optional complementary outputs with dead-time when PWM_DEADTIME_EN is defined.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH_DEF,
  parameter int unsigned CHANNELS = PWM_CHANNELS_DEF,
  parameter int unsigned DT_WIDTH = PWM_DT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  pwm_multi_if.slave   bus
);

  logic [WIDTH-1:0]          r_cnt;
  logic [WIDTH-1:0]          r_period_act;
  logic [WIDTH-1:0]          r_period_sh;
  logic [CHANNELS*WIDTH-1:0] r_duty_act;
  logic [CHANNELS*WIDTH-1:0] r_duty_sh;
  logic                      r_pending;
  logic                      r_period_end;
  logic [CHANNELS-1:0]       r_cmp;

  logic                      w_wrap;
  logic                      w_apply;
  logic [WIDTH-1:0]          w_cnt_nxt;
  logic [WIDTH-1:0]          w_period_nxt;
  logic [CHANNELS*WIDTH-1:0] w_duty_nxt;
  logic [CHANNELS-1:0]       w_cmp_nxt;

  if (CHANNELS < 1 || DT_WIDTH < 1) begin : g_param_check
    $error("pwm_multi: CHANNELS and DT_WIDTH must be >= 1");
  end

  assign w_wrap  = (r_cnt == r_period_act);
  assign w_apply = r_pending && (w_wrap || !bus.en);

  // Outputs are registered against the values the counter and active regs take next,
  // so out/period_end line up with the cnt value of the same cycle.
  always_comb begin
    w_cnt_nxt    = WIDTH'(CNT_RST);
    w_period_nxt = r_period_act;
    w_duty_nxt   = r_duty_act;
    w_cmp_nxt    = '0;
    if (bus.en && !w_wrap) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end
    if (w_apply) begin
      w_period_nxt = r_period_sh;
      w_duty_nxt   = r_duty_sh;
    end
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_cmp_nxt[i] = (w_cnt_nxt < w_duty_nxt[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= WIDTH'(CNT_RST);
      r_period_act <= '0;
      r_period_sh  <= '0;
      r_duty_act   <= '0;
      r_duty_sh    <= '0;
      r_pending    <= 1'b0;
      r_period_end <= 1'b0;
      r_cmp        <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_period_act <= w_period_nxt;
      r_duty_act   <= w_duty_nxt;
      r_period_end <= bus.en && (w_cnt_nxt == w_period_nxt);
      r_cmp        <= bus.en ? w_cmp_nxt : '0;
      // A load coinciding with apply lands in the shadow after the old shadow moved on
      if (bus.load) begin
        r_period_sh <= bus.period;
        r_duty_sh   <= bus.duty;
        r_pending   <= 1'b1;
      end else if (w_apply) begin
        r_pending   <= 1'b0;
      end
    end
  end

  assign bus.pending    = r_pending;
  assign bus.period_end = r_period_end;

`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0] r_dt_sh;
  logic [DT_WIDTH-1:0] r_dt_act;
  logic [CHANNELS-1:0] w_out;
  logic [CHANNELS-1:0] w_out_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dt_sh  <= '0;
      r_dt_act <= '0;
    end else begin
      if (w_apply)  r_dt_act <= r_dt_sh;
      if (bus.load) r_dt_sh  <= bus.deadtime;
    end
  end

  for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_dt
    pwm_multi_deadtime #(
      .DT_WIDTH (DT_WIDTH)
    ) u_dt (
      .clk        (clk),
      .rst        (rst),
      .i_en       (bus.en),
      .i_raw      (r_cmp[gi]),
      .i_deadtime (r_dt_act),
      .o_out      (w_out[gi]),
      .o_out_n    (w_out_n[gi])
    );
  end

  assign bus.out   = w_out;
  assign bus.out_n = w_out_n;
`else
  assign bus.out = r_cmp;
`endif

endmodule
